// File: rtl/cdb_pkg.sv
// Shared types and constants for the common data bus arbiter and its source FIFOs.
package cdb_pkg;

  localparam int unsigned ROB_W  = 6;
  localparam int unsigned DATA_W = 32;

  localparam logic [ROB_W-1:0] invalidNum = 6'b010000;

  typedef enum logic [1:0] {
    SRC_ADD = 2'd0,
    SRC_MUL = 2'd1,
    SRC_LD  = 2'd2,
    SRC_BR  = 2'd3
  } cdb_src_e;

  typedef struct packed {
    logic [ROB_W-1:0]  robNum;
    logic [DATA_W-1:0] data;
  } cdb_entry_t;

  localparam cdb_entry_t CDB_IDLE = '{robNum: invalidNum, data: '0};

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO: push/pop in the same cycle keeps the count, flush empties it.
module cdb_src_fifo
  import cdb_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  cdb_entry_t       data_i,
  output cdb_entry_t       head_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef logic [PTR_W-1:0] ptr_t;

  cdb_entry_t       mem_q [DEPTH];
  ptr_t             wr_q, wr_d;
  ptr_t             rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic ptr_t ptr_inc(ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push_i && (cnt_q != CNT_W'(DEPTH)) && !flush_i;
  assign do_pop  = pop_i && (cnt_q != '0) && !flush_i;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = ptr_inc(wr_q);
      if (do_pop)  rd_d = ptr_inc(rd_q);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: a head is only consumed when the count says it is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/cdb_arbiter.sv
// Dual-channel CDB arbiter: round-robin over per-source FIFO heads, two registered broadcasts per cycle.
module cdb_arbiter #(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned ROB_W      = cdb_pkg::ROB_W,
  parameter int unsigned DATA_W     = cdb_pkg::DATA_W,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*ROB_W-1:0]  src_robNum,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic                      CDBiscast,
  output logic [ROB_W-1:0]          CDBrobNum,
  output logic [DATA_W-1:0]         CDBdata,
  output logic                      CDBiscast2,
  output logic [ROB_W-1:0]          CDBrobNum2,
  output logic [DATA_W-1:0]         CDBdata2
);

  import cdb_pkg::*;

  localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  typedef logic [IDX_W-1:0] idx_t;

  cdb_entry_t       head      [NUM_SRC];
  logic [CNT_W-1:0] count     [NUM_SRC];
  logic [NUM_SRC-1:0] push, pop, not_empty;

  idx_t       rr_q, rr_d;
  idx_t       scan_idx;
  logic       gnt0_vld, gnt1_vld;
  idx_t       gnt0_idx, gnt1_idx;
  logic       iscast0_q, iscast0_d, iscast1_q, iscast1_d;
  cdb_entry_t cdb0_q, cdb0_d, cdb1_q, cdb1_d;

  function automatic idx_t next_idx(idx_t i);
    return idx_t'((32'(i) + 32'd1) % NUM_SRC);
  endfunction

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    cdb_entry_t wr_entry;

    assign wr_entry     = '{robNum: src_robNum[i*ROB_W +: ROB_W],
                            data:   src_data[i*DATA_W +: DATA_W]};
    assign src_ready[i] = (count[i] != CNT_W'(FIFO_DEPTH));
    assign not_empty[i] = (count[i] != '0);
    assign push[i]      = src_valid[i] & src_ready[i] & ~flush;
    assign pop[i]       = (gnt0_vld && (gnt0_idx == idx_t'(i))) ||
                          (gnt1_vld && (gnt1_idx == idx_t'(i)));

    cdb_src_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk_i   (clock),
      .rst_ni  (reset),
      .flush_i (flush),
      .push_i  (push[i]),
      .pop_i   (pop[i]),
      .data_i  (wr_entry),
      .head_o  (head[i]),
      .count_o (count[i])
    );
  end

  // First two non-empty heads found scanning upward from rr_q take channel 0 then channel 1.
  always_comb begin
    gnt0_vld = 1'b0;
    gnt1_vld = 1'b0;
    gnt0_idx = '0;
    gnt1_idx = '0;
    scan_idx = '0;
    if (!flush) begin
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
        scan_idx = idx_t'((32'(rr_q) + k) % NUM_SRC);
        if (not_empty[scan_idx]) begin
          if (!gnt0_vld) begin
            gnt0_vld = 1'b1;
            gnt0_idx = scan_idx;
          end else if (!gnt1_vld) begin
            gnt1_vld = 1'b1;
            gnt1_idx = scan_idx;
          end
        end
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (gnt1_vld)      rr_d = next_idx(gnt1_idx);
    else if (gnt0_vld) rr_d = next_idx(gnt0_idx);
  end

  always_comb begin
    iscast0_d = gnt0_vld;
    iscast1_d = gnt1_vld;
    cdb0_d    = gnt0_vld ? head[gnt0_idx] : CDB_IDLE;
    cdb1_d    = gnt1_vld ? head[gnt1_idx] : CDB_IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_q      <= '0;
      iscast0_q <= 1'b0;
      iscast1_q <= 1'b0;
      cdb0_q    <= CDB_IDLE;
      cdb1_q    <= CDB_IDLE;
    end else begin
      rr_q      <= rr_d;
      iscast0_q <= iscast0_d;
      iscast1_q <= iscast1_d;
      cdb0_q    <= cdb0_d;
      cdb1_q    <= cdb1_d;
    end
  end

  assign CDBiscast  = iscast0_q;
  assign CDBrobNum  = cdb0_q.robNum;
  assign CDBdata    = cdb0_q.data;
  assign CDBiscast2 = iscast1_q;
  assign CDBrobNum2 = cdb1_q.robNum;
  assign CDBdata2   = cdb1_q.data;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter with hand-computed expected broadcasts.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  logic         clock = 1'b0;
  logic         reset;
  logic         flush;
  logic [3:0]   src_valid;
  logic [23:0]  src_robNum;
  logic [127:0] src_data;
  logic [3:0]   src_ready;
  logic         CDBiscast, CDBiscast2;
  logic [5:0]   CDBrobNum, CDBrobNum2;
  logic [31:0]  CDBdata, CDBdata2;
  logic [77:0]  bus;

  int checks = 0;
  int errors = 0;

  localparam logic [77:0] BUS_IDLE = {1'b0, invalidNum, 32'h0, 1'b0, invalidNum, 32'h0};

  cdb_arbiter #(
    .NUM_SRC    (4),
    .ROB_W      (6),
    .DATA_W     (32),
    .FIFO_DEPTH (2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .src_valid  (src_valid),
    .src_robNum (src_robNum),
    .src_data   (src_data),
    .src_ready  (src_ready),
    .CDBiscast  (CDBiscast),
    .CDBrobNum  (CDBrobNum),
    .CDBdata    (CDBdata),
    .CDBiscast2 (CDBiscast2),
    .CDBrobNum2 (CDBrobNum2),
    .CDBdata2   (CDBdata2)
  );

  always #5 clock = ~clock;

  assign bus = {CDBiscast, CDBrobNum, CDBdata, CDBiscast2, CDBrobNum2, CDBdata2};

  function automatic logic [31:0] td(logic [5:0] tag);
    return 32'hCAFE_0000 | 32'(tag);
  endfunction

  function automatic logic [77:0] bus1(logic [5:0] a, logic [31:0] da);
    return {1'b1, a, da, 1'b0, invalidNum, 32'h0};
  endfunction

  function automatic logic [77:0] bus2(logic [5:0] a, logic [31:0] da,
                                       logic [5:0] b, logic [31:0] db);
    return {1'b1, a, da, 1'b1, b, db};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_src();
    src_valid  = '0;
    src_robNum = '0;
    src_data   = '0;
  endtask

  task automatic drive(input int s, input logic [5:0] tag, input logic [31:0] d);
    src_valid[s]          = 1'b1;
    src_robNum[s*6 +: 6]  = tag;
    src_data[s*32 +: 32]  = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    flush = 1'b0;
    idle_src();
    #1 reset = 1'b0;
    #2;
    checks++;
    if (bus !== BUS_IDLE) begin
      errors++;
      $display("FAIL reset_bus: got %h expected %h", bus, BUS_IDLE);
    end
    checks++;
    if (src_ready !== 4'hF) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1111", src_ready);
    end
    repeat (2) @(posedge clock);
    #7 reset = 1'b1;
    tick();
    checks++;
    if (bus !== BUS_IDLE) begin
      errors++;
      $display("FAIL reset_release_bus: got %h expected %h", bus, BUS_IDLE);
    end
  endtask

  task automatic test_dual_issue();
    drive(SRC_MUL, 6'd7, 32'hA);
    drive(SRC_BR,  6'd9, 32'hB);
    tick();
    checks++;
    if (bus !== BUS_IDLE) begin
      errors++;
      $display("FAIL dual_push_edge: got %h expected %h", bus, BUS_IDLE);
    end
    idle_src();
    tick();
    checks++;
    if (bus !== bus2(6'd7, 32'hA, 6'd9, 32'hB)) begin
      errors++;
      $display("FAIL dual_bcast: got %h expected %h", bus, bus2(6'd7, 32'hA, 6'd9, 32'hB));
    end
    tick();
    checks++;
    if (bus !== BUS_IDLE) begin
      errors++;
      $display("FAIL dual_after: got %h expected %h", bus, BUS_IDLE);
    end
  endtask

  task automatic test_back_pressure();
    logic [5:0] t0, t1;
    logic [5:0] q[$];
    logic [3:0] rdy;
    int n2, accepted, bcast;
    t0 = 6'd1; t1 = 6'd17; n2 = 0; accepted = 0; bcast = 0;
    for (int c = 0; c < 14; c++) begin
      idle_src();
      if (c < 8) begin
        drive(SRC_ADD, t0, td(t0));
        drive(SRC_MUL, t1, td(t1));
        if (n2 < 3) drive(SRC_LD, 6'(40 + n2), td(6'(40 + n2)));
      end
      rdy = src_ready;
      tick();
      if (src_valid[0] && rdy[0]) begin t0++; accepted++; end
      if (src_valid[1] && rdy[1]) begin t1++; accepted++; end
      if (src_valid[2] && rdy[2]) begin n2++; accepted++; end
      if (CDBiscast) begin
        bcast++;
        if (CDBrobNum inside {[6'd40:6'd42]}) q.push_back(CDBrobNum);
      end
      if (CDBiscast2) begin
        bcast++;
        if (CDBrobNum2 inside {[6'd40:6'd42]}) q.push_back(CDBrobNum2);
      end
      checks++;
      if (CDBiscast2 && !CDBiscast) begin
        errors++;
        $display("FAIL bp_channel_order: cycle %0d iscast=%b iscast2=%b", c, CDBiscast, CDBiscast2);
      end
      if (c == 1) begin
        checks++;
        if (bus !== bus2(6'd1, td(6'd1), 6'd17, td(6'd17))) begin
          errors++;
          $display("FAIL bp_first_pair: got %h expected %h", bus, bus2(6'd1, td(6'd1), 6'd17, td(6'd17)));
        end
        checks++;
        if (src_ready[2] !== 1'b0) begin
          errors++;
          $display("FAIL bp_ready_drop: got %b expected 0", src_ready[2]);
        end
      end
      if (c == 2) begin
        checks++;
        if ({CDBrobNum, CDBrobNum2} !== {6'd40, 6'd2}) begin
          errors++;
          $display("FAIL bp_ld_grant: got %0d/%0d expected 40/2", CDBrobNum, CDBrobNum2);
        end
      end
    end
    checks++;
    if (!(q.size() == 3 && q[0] == 6'd40 && q[1] == 6'd41 && q[2] == 6'd42)) begin
      errors++;
      $display("FAIL bp_ld_order: got %0d ld broadcasts expected 3 in order 40,41,42", q.size());
    end
    checks++;
    if (bcast !== accepted) begin
      errors++;
      $display("FAIL bp_conservation: got %0d broadcasts expected %0d", bcast, accepted);
    end
  endtask

  task automatic test_single_push();
    idle_src();
    drive(SRC_ADD, 6'd5, 32'h1234);
    tick();
    idle_src();
    tick();
    checks++;
    if (bus !== bus1(6'd5, 32'h1234)) begin
      errors++;
      $display("FAIL single_bcast: got %h expected %h", bus, bus1(6'd5, 32'h1234));
    end
    tick();
    checks++;
    if (bus !== BUS_IDLE) begin
      errors++;
      $display("FAIL single_pulse: got %h expected %h", bus, BUS_IDLE);
    end
  endtask

  task automatic test_flush();
    drive(SRC_ADD, 6'd1,  td(6'd1));
    drive(SRC_MUL, 6'd33, td(6'd33));
    drive(SRC_LD,  6'd34, td(6'd34));
    tick();
    drive(SRC_ADD, 6'd2,  td(6'd2));
    drive(SRC_MUL, 6'd35, td(6'd35));
    drive(SRC_LD,  6'd36, td(6'd36));
    tick();
    checks++;
    if (bus !== bus2(6'd33, td(6'd33), 6'd34, td(6'd34))) begin
      errors++;
      $display("FAIL flush_pre_pair: got %h expected %h", bus, bus2(6'd33, td(6'd33), 6'd34, td(6'd34)));
    end
    checks++;
    if (src_ready !== 4'b1110) begin
      errors++;
      $display("FAIL flush_pre_ready: got %b expected 1110", src_ready);
    end
    idle_src();
    flush = 1'b1;
    drive(SRC_ADD, 6'd3, td(6'd3));
    tick();
    flush = 1'b0;
    idle_src();
    checks++;
    if (bus !== BUS_IDLE) begin
      errors++;
      $display("FAIL flush_bus: got %h expected %h", bus, BUS_IDLE);
    end
    checks++;
    if (src_ready !== 4'hF) begin
      errors++;
      $display("FAIL flush_ready: got %b expected 1111", src_ready);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (bus !== BUS_IDLE) begin
        errors++;
        $display("FAIL flush_quiet: cycle %0d got %h expected %h", c, bus, BUS_IDLE);
      end
    end
    drive(SRC_ADD, 6'd51, td(6'd51));
    drive(SRC_BR,  6'd50, td(6'd50));
    tick();
    idle_src();
    tick();
    checks++;
    if (bus !== bus2(6'd50, td(6'd50), 6'd51, td(6'd51))) begin
      errors++;
      $display("FAIL flush_rr_kept: got %h expected %h", bus, bus2(6'd50, td(6'd50), 6'd51, td(6'd51)));
    end
    tick();
  endtask

  task automatic test_async_reset();
    for (int s = 0; s < 4; s++) drive(s, 6'(20 + s), td(6'(20 + s)));
    tick();
    for (int s = 0; s < 4; s++) drive(s, 6'(24 + s), td(6'(24 + s)));
    tick();
    checks++;
    if (bus !== bus2(6'd21, td(6'd21), 6'd22, td(6'd22))) begin
      errors++;
      $display("FAIL areset_pre: got %h expected %h", bus, bus2(6'd21, td(6'd21), 6'd22, td(6'd22)));
    end
    #2 reset = 1'b0;
    idle_src();
    #1;
    checks++;
    if (bus !== BUS_IDLE) begin
      errors++;
      $display("FAIL areset_bus: got %h expected %h", bus, BUS_IDLE);
    end
    checks++;
    if (src_ready !== 4'hF) begin
      errors++;
      $display("FAIL areset_ready: got %b expected 1111", src_ready);
    end
    #2 reset = 1'b1;
    drive(SRC_ADD, 6'd11, td(6'd11));
    drive(SRC_BR,  6'd12, td(6'd12));
    tick();
    idle_src();
    checks++;
    if (bus !== BUS_IDLE) begin
      errors++;
      $display("FAIL areset_first_edge: got %h expected %h", bus, BUS_IDLE);
    end
    tick();
    checks++;
    if (bus !== bus2(6'd11, td(6'd11), 6'd12, td(6'd12))) begin
      errors++;
      $display("FAIL areset_second_edge: got %h expected %h", bus, bus2(6'd11, td(6'd11), 6'd12, td(6'd12)));
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (bus !== BUS_IDLE) begin
        errors++;
        $display("FAIL areset_quiet: cycle %0d got %h expected %h", c, bus, BUS_IDLE);
      end
    end
  endtask

  task automatic test_fairness();
    int k[4];
    logic [3:0] rdy;
    int lo, kk;
    logic [5:0] e0, e1;
    logic [3:0] er;
    for (int s = 0; s < 4; s++) k[s] = 1;
    for (int c = 0; c < 5; c++) begin
      for (int s = 0; s < 4; s++) drive(s, 6'(s*8 + k[s]), td(6'(s*8 + k[s])));
      rdy = src_ready;
      tick();
      for (int s = 0; s < 4; s++) if (rdy[s]) k[s]++;
      if (c >= 1) begin
        lo = (((c - 1) % 2) == 0) ? 0 : 2;
        kk = (c - 1) / 2 + 1;
        e0 = 6'(lo*8 + kk);
        e1 = 6'((lo + 1)*8 + kk);
        er = (lo == 0) ? 4'b0011 : 4'b1100;
        checks++;
        if (bus !== bus2(e0, td(e0), e1, td(e1))) begin
          errors++;
          $display("FAIL fair_pair: cycle %0d got %h expected %h", c, bus, bus2(e0, td(e0), e1, td(e1)));
        end
        checks++;
        if (src_ready !== er) begin
          errors++;
          $display("FAIL fair_ready: cycle %0d got %b expected %b", c, src_ready, er);
        end
      end
    end
    idle_src();
    repeat (6) tick();
  endtask

  initial begin
    test_reset();
    test_dual_issue();
    test_back_pressure();
    test_single_push();
    test_flush();
    test_async_reset();
    test_fairness();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Collects completed results from the functional units (add RS, mul/div RS, load unit, branch unit) and drives the two common data bus channels consumed by every reservation station and the reorder buffer. Each source owns a small result FIFO. Up to two results leave per cycle under round-robin arbitration, so a unit that finishes while the bus is busy is back-pressured instead of losing its broadcast.

## Interface
Parameters:
- NUM_SRC, 4: number of producing units. Index 0 = add, 1 = mul, 2 = load, 3 = branch.
- ROB_W, 6: ROB tag width.
- DATA_W, 32: result width.
- FIFO_DEPTH, 2: entries per source FIFO. Must be a power of two, ≥1.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous mispredict flush; empties every FIFO.
- src_valid  in  NUM_SRC  per-source result present.
- src_robNum  in  NUM_SRC×ROB_W  per-source ROB tag, packed, source 0 in the LSBs.
- src_data  in  NUM_SRC×DATA_W  per-source result, packed.
- src_ready  out  NUM_SRC  per-source FIFO not full.
- CDBiscast  out  1  channel 0 valid; one-cycle pulse per result.
- CDBrobNum  out  ROB_W  channel 0 tag.
- CDBdata  out  DATA_W  channel 0 data.
- CDBiscast2, CDBrobNum2, CDBdata2  out  1/ROB_W/DATA_W  channel 1, same meaning as channel 0.

## Operation
- Push: in a cycle with src_valid[i] && src_ready[i], the {robNum, data} pair is written into FIFO i. When src_ready[i] is low, the push is ignored; the source must hold the result.
- src_ready[i] = (count_i != FIFO_DEPTH). It is combinational from the registered count only and does not depend on a pop in the same cycle.
- Arbitration happens every cycle over the FIFO heads:
  - Scan from rr_ptr upward, modulo NUM_SRC.
  - The first non-empty FIFO goes to channel 0. The second distinct non-empty FIFO goes to channel 1.
  - A source gets at most one grant per cycle.
- rr_ptr update:
  - Moves to (index of last granted source + 1) mod NUM_SRC.
  - Holds when nothing is granted.
  - Reset value is 0.
- Granted heads are popped, and their values are registered onto the CDB outputs.
- Unused channel: iscast = 0, robNum = invalidNum (6'b010000), data = 0.
- A FIFO may push and pop in the same cycle. Its count is then unchanged, and the pointers wrap modulo FIFO_DEPTH.
- Flush:
  - All counts and pointers are cleared, pushes in that cycle are dropped, and no grant is issued.
  - The next-cycle CDB outputs are idle.
  - rr_ptr is preserved.
- Channel 0 is never idle while channel 1 is valid.

## Timing
- All outputs are registered.
- A result pushed at edge N can appear on the CDB at edge N+1 at the earliest, as a single-cycle pulse.
- Throughput: 2 results per cycle total, at most 1 per source per cycle.
- Worst-case wait for a non-empty FIFO: ceil((NUM_SRC−1)/2) cycles once it is non-empty, because round-robin order guarantees fairness.
- Reset (asynchronous, active-low), effective immediately and independent of clock:
  - CDBiscast = CDBiscast2 = 0.
  - CDBrobNum = CDBrobNum2 = invalidNum.
  - CDBdata = CDBdata2 = 0.
  - All FIFOs empty, src_ready all 1, rr_ptr = 0.
- Reset asserted mid-burst discards all queued results. The first broadcast after deassertion comes no earlier than the second rising edge following deassertion.
- Flush and reset both override a simultaneous push and pop.

## Structure
- Shared package cdb_pkg holds:
  - ROB_W, DATA_W, invalidNum = 6'b010000.
  - The source index constants (SRC_ADD=0, SRC_MUL=1, SRC_LD=2, SRC_BR=3).
  - A packed cdb_entry_t {robNum, data}.
- One sub-module, cdb_src_fifo (depth FIFO_DEPTH, entry cdb_entry_t, push/pop/flush, count, head), instantiated NUM_SRC times.
- Arbitration and output registers live in cdb_arbiter itself.

## Test plan
- Single push: src 0 pushes {robNum 5, data 0x1234} at edge 1 → at edge 2, CDBiscast=1, CDBrobNum=5, CDBdata=0x1234, channel 1 idle. Edge 3: all idle.
- Dual issue: srcs 1 and 3 push (7, 0xA) and (9, 0xB) in the same cycle with rr_ptr=0 → the next cycle carries channel 0 = tag 7 and channel 1 = tag 9, and rr_ptr becomes 0.
- Fairness: all 4 sources push every cycle while ready → grant pairs alternate {0,1}, {2,3}, {0,1}, and no source is starved for more than 1 cycle.
- Back-pressure: src 2 pushes 3 results while srcs 0 and 1 stream continuously → src_ready[2] drops after 2 unserviced pushes. The third push is held, then accepted. All 3 tags appear exactly once, in order.
- Flush: fill FIFO 0 with tags 1 and 2, assert flush alongside a push of tag 3 → CDB idle next cycle, src_ready[0]=1, and tags 1, 2 and 3 never broadcast.
- Async reset: deassert-reassert reset between clock edges while FIFOs are full → outputs go immediately to 0 / invalidNum / 0, and nothing is broadcast afterwards without new pushes.
